// File: rtl/gmii_tx_arb_pkg.sv
// rtl/gmii_tx_arb_pkg.sv - shared Ethernet constants: arbiter state encodings and timing defaults
package gmii_tx_arb_pkg;

  localparam int IFG_CYCLES_DEF    = 12;
  localparam int GRANT_TIMEOUT_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_XMIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gmii_tx_arb.sv
// rtl/gmii_tx_arb.sv - two-source round-robin GMII transmit arbiter with inter-frame gap and grant timeout
module gmii_tx_arb
  import gmii_tx_arb_pkg::*;
#(
  parameter int IFG_CYCLES    = IFG_CYCLES_DEF,
  parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic       src0_req,
  input  logic       src1_req,
  output logic       src0_grant,
  output logic       src1_grant,
  input  logic       src0_tx_en,
  input  logic       src1_tx_en,
  input  logic [7:0] src0_txd,
  input  logic [7:0] src1_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       timeout_err
);

  localparam int CNT_W = $clog2(max_int(IFG_CYCLES, GRANT_TIMEOUT) + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             sel;
  logic             last;
  logic             pick;
  logic             sel_tx_en;
  logic [7:0]       sel_txd;

  assign src0_grant = grant & ~sel;
  assign src1_grant = grant & sel;

  assign sel_tx_en = sel ? src1_tx_en : src0_tx_en;
  assign sel_txd   = sel ? src1_txd   : src0_txd;

  // On a tie the source not served last wins; a lone requester always wins.
  assign pick = (src0_req & src1_req) ? ~last : src1_req;

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      grant       <= 1'b0;
      sel         <= 1'b0;
      last        <= 1'b1;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      // Only the granted source is forwarded, and only while the grant is live.
      if ((state == ST_GRANT || state == ST_XMIT) && sel_tx_en) begin
        gmii_tx_en <= 1'b1;
        gmii_txd   <= sel_txd;
      end

      case (state)
        ST_IDLE: begin
          if (src0_req | src1_req) begin
            sel   <= pick;
            last  <= pick;
            grant <= 1'b1;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (sel_tx_en) begin
            cnt   <= '0;
            state <= ST_XMIT;
          end else if (cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
            grant       <= 1'b0;
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_XMIT: begin
          if (!sel_tx_en) begin
            grant <= 1'b0;
            cnt   <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          grant <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_arb.sv
// tb/tb_gmii_tx_arb.sv - directed self-checking bench for gmii_tx_arb
module tb_gmii_tx_arb;

  localparam int IFG = 12;
  localparam int TO  = 16;

  logic       gmii_tx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       src0_req = 1'b0, src1_req = 1'b0;
  logic       src0_tx_en = 1'b0, src1_tx_en = 1'b0;
  logic [7:0] src0_txd = 8'h00, src1_txd = 8'h00;
  logic       src0_grant, src1_grant;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       timeout_err;

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  gmii_tx_arb #(.IFG_CYCLES(IFG), .GRANT_TIMEOUT(TO)) dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst         (rst),
    .src0_req    (src0_req),
    .src1_req    (src1_req),
    .src0_grant  (src0_grant),
    .src1_grant  (src1_grant),
    .src0_tx_en  (src0_tx_en),
    .src1_tx_en  (src1_tx_en),
    .src0_txd    (src0_txd),
    .src1_txd    (src1_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .timeout_err (timeout_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int to_pulses = 0;
  bit mon_on = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge gmii_tx_clk) begin
    if (mon_on) begin
      chk_eq("one_grant", 32'(src0_grant & src1_grant), 32'd0);
      if (timeout_err) to_pulses++;
    end
  end

  task automatic tick();
    @(negedge gmii_tx_clk);
  endtask

  task automatic set_src(input int s, input logic en, input logic [7:0] d);
    if (s == 0) begin
      src0_tx_en = en;
      src0_txd   = d;
    end else begin
      src1_tx_en = en;
      src1_txd   = d;
    end
  endtask

  task automatic wait_grant(output int s, output int lat);
    s   = -1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (src0_grant | src1_grant) begin
        s   = src1_grant ? 1 : 0;
        lat = n;
        break;
      end
    end
    if (s < 0) chk_eq("grant_wait", 32'(src0_grant | src1_grant), 32'd1);
  endtask

  task automatic drive_frame(input int s, input int len, input logic [7:0] base, input bit noise);
    for (int i = 0; i <= len; i++) begin
      if (i == 0) begin
        chk_eq("lead_en", 32'(gmii_tx_en), 32'd0);
      end else begin
        chk_eq("fwd_en", 32'(gmii_tx_en), 32'd1);
        chk_eq("fwd_txd", 32'(gmii_txd), 32'(8'(base + 8'(i - 1))));
      end
      chk_eq("other_grant", 32'((s == 0) ? src1_grant : src0_grant), 32'd0);
      set_src(s, i < len, (i < len) ? 8'(base + 8'(i)) : 8'h00);
      if (noise) set_src(1 - s, 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end
    if (noise) set_src(1 - s, 1'b0, 8'h00);
  endtask

  task automatic check_gap(input int exp_len);
    int c = 0;
    while (!(src0_grant | src1_grant) && c < 40) begin
      chk_eq("gap_en", 32'(gmii_tx_en), 32'd0);
      chk_eq("gap_txd", 32'(gmii_txd), 32'd0);
      c++;
      tick();
    end
    chk_eq("gap_len", 32'(c), 32'(exp_len));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk_eq("idle_en", 32'(gmii_tx_en), 32'd0);
      chk_eq("idle_grant", 32'(src0_grant | src1_grant), 32'd0);
      tick();
    end
  endtask

  int s, lat, c;
  int tie_exp[4] = '{0, 1, 0, 1};

  initial begin
    repeat (3) tick();
    chk_eq("rst_en", 32'(gmii_tx_en), 32'd0);
    chk_eq("rst_txd", 32'(gmii_txd), 32'd0);
    chk_eq("rst_grants", 32'({src0_grant, src1_grant}), 32'd0);
    chk_eq("rst_timeout", 32'(timeout_err), 32'd0);
    mon_on = 1'b1;

    // Tie from reset release: src0 first, then strict alternation.
    rst = 1'b0;
    src0_req = 1'b1;
    src1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(s, lat);
      chk_eq("tie_order", 32'(s), 32'(tie_exp[k]));
      if (k == 0) chk_eq("tie_lat", 32'(lat), 32'd1);
      if (k == 2) src0_req = 1'b0;
      if (k == 3) src1_req = 1'b0;
      drive_frame(s, 8, 8'(8'h10 * (k + 1)), 1'b0);
      if (k < 3) check_gap(IFG + 1);
    end
    idle_cycles(IFG + 2);

    // Single requester, 64-byte frame, src1 toggling noise.
    src0_req = 1'b1;
    wait_grant(s, lat);
    chk_eq("single_src", 32'(s), 32'd0);
    chk_eq("single_lat", 32'(lat), 32'd1);
    src0_req = 1'b0;
    drive_frame(0, 64, 8'h40, 1'b1);
    idle_cycles(IFG);

    // Grant timeout on src1 with src0 pending.
    src1_req = 1'b1;
    wait_grant(s, lat);
    chk_eq("to_src", 32'(s), 32'd1);
    chk_eq("to_lat", 32'(lat), 32'd1);
    src1_req = 1'b0;
    src0_req = 1'b1;
    to_pulses = 0;
    c = 0;
    while (src1_grant && c < 40) begin
      chk_eq("to_hold_en", 32'(gmii_tx_en), 32'd0);
      c++;
      tick();
    end
    chk_eq("to_hold_len", 32'(c), 32'(TO));
    chk_eq("to_err_pulse", 32'(timeout_err), 32'd1);
    check_gap(IFG + 1);
    chk_eq("to_next_src0", 32'(src0_grant), 32'd1);
    src0_req = 1'b0;
    drive_frame(0, 6, 8'hA0, 1'b1);
    idle_cycles(IFG);
    chk_eq("to_pulse_cnt", 32'(to_pulses), 32'd1);

    // Reset at byte 20 of a 100-byte frame, then an immediate new grant.
    src0_req = 1'b1;
    wait_grant(s, lat);
    chk_eq("mid_src", 32'(s), 32'd0);
    src0_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_src(0, 1'b1, 8'(i));
      tick();
    end
    chk_eq("pre_rst_en", 32'(gmii_tx_en), 32'd1);
    set_src(0, 1'b1, 8'd20);
    rst = 1'b1;
    tick();
    chk_eq("mid_rst_en", 32'(gmii_tx_en), 32'd0);
    chk_eq("mid_rst_grants", 32'({src0_grant, src1_grant}), 32'd0);
    rst = 1'b0;
    set_src(0, 1'b0, 8'h00);
    src1_req = 1'b1;
    tick();
    chk_eq("post_rst_grant1", 32'(src1_grant), 32'd1);
    src1_req = 1'b0;
    drive_frame(1, 4, 8'hC0, 1'b0);
    idle_cycles(IFG);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gmii_tx_arb.md
GMII_TX_ARB -- requirements
Module: gmii_tx_arb

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, meaning idle cycles forced on the GMII output between frames.
REQ-002 SHALL have parameter GRANT_TIMEOUT, default 16, meaning the maximum number of cycles from grant to first source tx_en before the grant is revoked.
REQ-003 SHALL have port gmii_tx_clk, input, 1, the single clock for all logic (125 MHz GMII transmit clock).
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have ports src0_req / src1_req, input, 1 each, a source requesting the link (level, held until granted).
REQ-006 SHALL have ports src0_grant / src1_grant, output, 1 each, the granted source may drive its frame.
REQ-007 SHALL have ports src0_tx_en / src1_tx_en, input, 1 each, source frame valid (contiguous for one frame).
REQ-008 SHALL have ports src0_txd / src1_txd, input, 8 each, source frame byte.
REQ-009 SHALL have port gmii_tx_en, output, 1, arbitrated GMII valid, feeding the RGMII transmit DDR stage.
REQ-010 SHALL have port gmii_txd, output, 8, arbitrated GMII data.
REQ-011 SHALL have port timeout_err, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 SHALL implement the states IDLE, GRANT, XMIT and GAP.
REQ-013 IDLE: when any req is high, SHALL select a source, assert its grant in the next cycle, and go to GRANT.
REQ-014 SHALL arbitrate round-robin: when both reqs are high, SHALL grant the source not served last; a single requester SHALL always win.
REQ-015 GRANT: when the granted source's tx_en is high, SHALL go to XMIT.
REQ-016 GRANT: after GRANT_TIMEOUT cycles with tx_en low, SHALL drop the grant, pulse timeout_err, and go to GAP.
REQ-017 XMIT: SHALL forward the granted source's tx_en/txd to gmii_tx_en/gmii_txd through one register stage (latency exactly 1 cycle).
REQ-018 XMIT: on the first cycle the granted tx_en is low, SHALL drop the grant in the next cycle and go to GAP.
REQ-019 GAP: SHALL hold gmii_tx_en=0 and gmii_txd=0 for exactly IFG_CYCLES cycles after the last valid output byte, then go to IDLE.
REQ-020 The non-granted source's tx_en and txd SHALL never reach the output; gmii_tx_en SHALL be 0 in IDLE, GRANT and GAP.
REQ-021 At most one grant SHALL be high at any time.
REQ-022 A req dropped while in GRANT SHALL be ignored; only tx_en or the timeout ends GRANT.
REQ-023 The last-served pointer SHALL update when a grant is issued, including grants later revoked by timeout.
REQ-024 The cycle counter SHALL be wide enough for max(IFG_CYCLES, GRANT_TIMEOUT) and SHALL be cleared on every state entry.

Reset
REQ-025 While rst is high (sampled on a gmii_tx_clk edge), SHALL set: state=IDLE, both grants=0, gmii_tx_en=0, gmii_txd=0, timeout_err=0, counter=0, last-served=src1 (so src0 wins the first tie).
REQ-026 Reset mid-frame SHALL force gmii_tx_en low in the cycle after the reset edge; no GAP is applied after reset.

Structure
REQ-027 SHALL keep the state encodings and the default IFG_CYCLES/GRANT_TIMEOUT values in the shared Ethernet package used by the GMII/RGMII blocks.
REQ-028 SHALL be a single module with no sub-modules; its outputs connect directly to the RGMII transmit DDR stage.

Verification
REQ-029 Single requester: src0_req=1; src0 sends a 64-byte frame -> grant 1 cycle after req; gmii_tx_en high for exactly 64 cycles, lagging src0_tx_en by 1; then 12 idle cycles.
REQ-030 Tie: both reqs high from reset release, two frames each -> grant order src0, src1, src0, src1; gap of exactly 12 cycles between each frame.
REQ-031 Timeout: src1 granted and never asserts tx_en -> grant drops after 16 cycles; timeout_err pulses once; then 12 idle cycles; a pending src0 is then granted.
REQ-032 Isolation: src1_tx_en toggling with random txd while src0 is transmitting -> output equals src0 data only; src1_grant stays 0.
REQ-033 Reset mid-frame: rst asserted at byte 20 of a 100-byte frame -> gmii_tx_en=0 and both grants=0 in the following cycle; a new request after release is granted immediately.
